// File: rtl/simple_proc_alu_core_if.sv
// Operand/result bundle for simple_proc_alu_core.
// Signals:
//   opcode           4  operation select
//   immediate_offset 7  immediate/offset field, [3:0] is the shift amount
//   operand_1        16 first operand (Rn)
//   operand_2        16 second operand (Rm)
//   result           16 registered result
//   overflow/carry/negative/zero  registered V/C/N/Z flags
// Modports: master drives operands and observes results, slave is the ALU.
interface simple_proc_alu_core_if;
    logic [3:0]  opcode;
    logic [6:0]  immediate_offset;
    logic [15:0] operand_1;
    logic [15:0] operand_2;
    logic [15:0] result;
    logic        overflow;
    logic        carry;
    logic        negative;
    logic        zero;

    modport master (
        output opcode, immediate_offset, operand_1, operand_2,
        input  result, overflow, carry, negative, zero
    );

    modport slave (
        input  opcode, immediate_offset, operand_1, operand_2,
        output result, overflow, carry, negative, zero
    );
endinterface

// File: rtl/simple_proc_alu_core.sv
// 16-bit registered ALU with sticky N/Z/C/V flags, one-cycle latency,
// accepting a new operation every clock.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, clears result and flags
//   bus  simple_proc_alu_core_if.slave (operands, opcode, immediate, result, flags)
// Build option: define SIMPLE_PROC_ALU_MUL_OVERFLOW_EN to make MUL update V
// from the full signed product; otherwise MUL holds both C and V.
module simple_proc_alu_core (
    input  logic                    clk,
    input  logic                    rst,
    simple_proc_alu_core_if.slave   bus
);
    localparam int unsigned DW = 16;
    localparam int unsigned SW = 4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_ORR  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_EOR  = 4'd5;
    localparam logic [3:0] OP_MOVI = 4'd6;
    localparam logic [3:0] OP_MOV  = 4'd7;
    localparam logic [3:0] OP_LSR  = 4'd8;
    localparam logic [3:0] OP_LSL  = 4'd9;
    localparam logic [3:0] OP_ROR  = 4'd10;
    localparam logic [3:0] OP_CMP  = 4'd11;
    localparam logic [3:0] OP_ADR  = 4'd12;

    logic [DW-1:0] result_q, result_d;
    logic          overflow_q, overflow_d;
    logic          carry_q, carry_d;
    logic          negative_q, negative_d;
    logic          zero_q, zero_d;

    logic [DW-1:0] a, b;
    logic [SW-1:0] sh;
    logic [DW:0]   sum_c;
    logic [DW:0]   diff_c;
    logic          sub_v_c;
    logic [DW-1:0] imm_c;
    logic [DW-1:0] mul_c;

    assign a     = bus.operand_1;
    assign b     = bus.operand_2;
    assign sh    = bus.immediate_offset[SW-1:0];
    assign imm_c = DW'(bus.immediate_offset);

    // 17-bit add/subtract expose carry-out and borrow in bit 16
    assign sum_c   = {1'b0, a} + {1'b0, b};
    assign diff_c  = {1'b0, a} - {1'b0, b};
    assign sub_v_c = (a[DW-1] != b[DW-1]) && (diff_c[DW-1] != a[DW-1]);

`ifdef SIMPLE_PROC_ALU_MUL_OVERFLOW_EN
    logic signed [2*DW-1:0] prod_c;
    logic                   mul_v_c;

    assign prod_c  = (2*DW)'($signed(a)) * (2*DW)'($signed(b));
    assign mul_c   = prod_c[DW-1:0];
    // Product fits in 16 signed bits iff bits [31:15] are all equal
    assign mul_v_c = !((&prod_c[2*DW-1:DW-1]) || !(|prod_c[2*DW-1:DW-1]));
`else
    // Low half of a product is identical for signed and unsigned operands
    assign mul_c = a * b;
`endif

    // Next result and flags per opcode; flags hold unless the opcode sets them
    always_comb begin
        result_d   = '0;
        overflow_d = overflow_q;
        carry_d    = carry_q;
        negative_d = negative_q;
        zero_d     = zero_q;

        unique case (bus.opcode)
            OP_ADD: begin
                result_d   = sum_c[DW-1:0];
                carry_d    = sum_c[DW];
                overflow_d = (a[DW-1] == b[DW-1]) && (sum_c[DW-1] != a[DW-1]);
                negative_d = sum_c[DW-1];
                zero_d     = (sum_c[DW-1:0] == '0);
            end
            OP_SUB, OP_CMP: begin
                // CMP writes 0 but flags come from the subtraction
                result_d   = (bus.opcode == OP_SUB) ? diff_c[DW-1:0] : '0;
                carry_d    = ~diff_c[DW];
                overflow_d = sub_v_c;
                negative_d = diff_c[DW-1];
                zero_d     = (diff_c[DW-1:0] == '0);
            end
            OP_MUL: begin
                result_d   = mul_c;
                negative_d = mul_c[DW-1];
                zero_d     = (mul_c == '0);
`ifdef SIMPLE_PROC_ALU_MUL_OVERFLOW_EN
                overflow_d = mul_v_c;
`endif
            end
            OP_ORR:  result_d = a | b;
            OP_AND:  result_d = a & b;
            OP_EOR:  result_d = a ^ b;
            OP_MOVI: result_d = imm_c;
            OP_MOV:  result_d = a;
            OP_LSR:  result_d = a >> sh;
            OP_LSL:  result_d = a << sh;
            // Left term vanishes for sh=0 since a 16-bit value shifted by 16 is 0
            OP_ROR:  result_d = (a >> sh) | (a << (5'(DW) - 5'(sh)));
            OP_ADR:  result_d = imm_c;
            default: result_d = '0;
        endcase
    end

    // Result and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q   <= '0;
            overflow_q <= 1'b0;
            carry_q    <= 1'b0;
            negative_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            result_q   <= result_d;
            overflow_q <= overflow_d;
            carry_q    <= carry_d;
            negative_q <= negative_d;
            zero_q     <= zero_d;
        end
    end

    assign bus.result   = result_q;
    assign bus.overflow = overflow_q;
    assign bus.carry    = carry_q;
    assign bus.negative = negative_q;
    assign bus.zero     = zero_q;
endmodule

// File: tb/tb_simple_proc_alu_core.sv
// Directed testbench for simple_proc_alu_core; flags compared as {N,Z,C,V}.
module tb_simple_proc_alu_core;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    simple_proc_alu_core_if alu_if ();

    simple_proc_alu_core dut (
        .clk (clk),
        .rst (rst),
        .bus (alu_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] flags();
        return {alu_if.negative, alu_if.zero, alu_if.carry, alu_if.overflow};
    endfunction

    // Apply one operation on the falling edge, sample just after the rising edge
    task automatic do_op(input logic [3:0] op, input logic [6:0] imm,
                         input logic [15:0] op1, input logic [15:0] op2);
        @(negedge clk);
        alu_if.opcode           = op;
        alu_if.immediate_offset = imm;
        alu_if.operand_1        = op1;
        alu_if.operand_2        = op2;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        do_op(4'd0, 7'h00, 16'hFFFF, 16'h0001);   // leaves Z=1 C=1
        @(negedge clk);
        rst = 1'b1;
        alu_if.opcode    = 4'd0;
        alu_if.operand_1 = 16'h7FFF;
        alu_if.operand_2 = 16'h0001;
        @(posedge clk);
        #1;
        checks++;
        if (alu_if.result !== 16'h0000) begin
            errors++;
            $display("FAIL reset_result got %h want 0000", alu_if.result);
        end
        checks++;
        if (flags() !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", flags());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        do_op(4'd0, 7'h00, 16'h7FFF, 16'h0001);
        checks++;
        if ({alu_if.result, flags()} !== {16'h8000, 4'b1001}) begin
            errors++;
            $display("FAIL add_ovf got %h/%b want 8000/1001", alu_if.result, flags());
        end
        do_op(4'd0, 7'h00, 16'hFFFF, 16'h0001);
        checks++;
        if ({alu_if.result, flags()} !== {16'h0000, 4'b0110}) begin
            errors++;
            $display("FAIL add_carry got %h/%b want 0000/0110", alu_if.result, flags());
        end
    endtask

    task automatic test_sub();
        do_op(4'd1, 7'h00, 16'h0005, 16'h0005);
        checks++;
        if ({alu_if.result, flags()} !== {16'h0000, 4'b0110}) begin
            errors++;
            $display("FAIL sub_eq got %h/%b want 0000/0110", alu_if.result, flags());
        end
        do_op(4'd1, 7'h00, 16'h0002, 16'h0003);
        checks++;
        if ({alu_if.result, flags()} !== {16'hFFFF, 4'b1000}) begin
            errors++;
            $display("FAIL sub_borrow got %h/%b want ffff/1000", alu_if.result, flags());
        end
        do_op(4'd1, 7'h00, 16'h8000, 16'h0001);
        checks++;
        if ({alu_if.result, flags()} !== {16'h7FFF, 4'b0011}) begin
            errors++;
            $display("FAIL sub_ovf got %h/%b want 7fff/0011", alu_if.result, flags());
        end
    endtask

    task automatic test_cmp_orr();
        do_op(4'd11, 7'h00, 16'h0003, 16'h0005);
        checks++;
        if ({alu_if.result, flags()} !== {16'h0000, 4'b1000}) begin
            errors++;
            $display("FAIL cmp_lt got %h/%b want 0000/1000", alu_if.result, flags());
        end
        do_op(4'd3, 7'h00, 16'h00F0, 16'h000F);
        checks++;
        if ({alu_if.result, flags()} !== {16'h00FF, 4'b1000}) begin
            errors++;
            $display("FAIL orr_hold got %h/%b want 00ff/1000", alu_if.result, flags());
        end
        do_op(4'd11, 7'h00, 16'h0005, 16'h0005);
        checks++;
        if ({alu_if.result, flags()} !== {16'h0000, 4'b0110}) begin
            errors++;
            $display("FAIL cmp_eq got %h/%b want 0000/0110", alu_if.result, flags());
        end
    endtask

    task automatic test_mul();
        do_op(4'd0, 7'h00, 16'h8000, 16'h8000);   // sets Z=1 C=1 V=1
        checks++;
        if ({alu_if.result, flags()} !== {16'h0000, 4'b0111}) begin
            errors++;
            $display("FAIL mul_setup got %h/%b want 0000/0111", alu_if.result, flags());
        end
        do_op(4'd2, 7'h00, 16'hFFFD, 16'h0004);
        checks++;
        if ({alu_if.result, flags()} !== {16'hFFF4, 4'b1011}) begin
            errors++;
            $display("FAIL mul_neg got %h/%b want fff4/1011", alu_if.result, flags());
        end
        do_op(4'd0, 7'h00, 16'h0001, 16'h0002);   // clears all flags
        do_op(4'd2, 7'h00, 16'h0100, 16'h0100);
        checks++;
        if ({alu_if.result, flags()} !== {16'h0000, 4'b0100}) begin
            errors++;
            $display("FAIL mul_zero got %h/%b want 0000/0100", alu_if.result, flags());
        end
    endtask

    task automatic test_shift_imm();
        logic [3:0]  ops  [8] = '{4'd10, 4'd10, 4'd9, 4'd8, 4'd6, 4'd13, 4'd10, 4'd12};
        logic [6:0]  imms [8] = '{7'h01, 7'h00, 7'h0F, 7'h04, 7'h7F, 7'h00, 7'h14, 7'h55};
        logic [15:0] a    [8] = '{16'h0001, 16'h0001, 16'h0001, 16'hF000,
                                  16'h0001, 16'h0001, 16'h0001, 16'h0001};
        logic [15:0] exp  [8] = '{16'h8000, 16'h0001, 16'h8000, 16'h0F00,
                                  16'h007F, 16'h0000, 16'h1000, 16'h0055};
        do_op(4'd1, 7'h00, 16'h0002, 16'h0003);   // flags 1000
        for (int i = 0; i < 8; i++) begin
            do_op(ops[i], imms[i], a[i], 16'hAAAA);
            checks++;
            if ({alu_if.result, flags()} !== {exp[i], 4'b1000}) begin
                errors++;
                $display("FAIL shift_imm[%0d] got %h/%b want %h/1000",
                         i, alu_if.result, flags(), exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [6] = '{4'd0, 4'd5, 4'd4, 4'd7, 4'd14, 4'd15};
        logic [15:0] exp [6] = '{16'h0003, 16'hF0F0, 16'h0F00, 16'hFF00, 16'h0000, 16'h0000};
        logic [15:0] a   [6] = '{16'h0001, 16'hFF00, 16'hFF00, 16'hFF00, 16'h1234, 16'h1234};
        logic [15:0] b   [6] = '{16'h0002, 16'h0FF0, 16'h0FF0, 16'h0FF0, 16'h1234, 16'h1234};
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], 7'h33, a[i], b[i]);
            checks++;
            if ({alu_if.result, flags()} !== {exp[i], 4'b0000}) begin
                errors++;
                $display("FAIL b2b[%0d] got %h/%b want %h/0000",
                         i, alu_if.result, flags(), exp[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        alu_if.opcode           = 4'd0;
        alu_if.immediate_offset = 7'h00;
        alu_if.operand_1        = 16'h0000;
        alu_if.operand_2        = 16'h0000;
        repeat (2) @(posedge clk);
        test_reset();
        test_add();
        test_sub();
        test_cmp_orr();
        test_mul();
        test_shift_imm();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
